// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between the CPU word port and
// a 256-bit line-granular physical memory port.
module l1_cache #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned NUM_SETS = 1 << S_INDEX;
    localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int unsigned S_WORD   = S_OFFSET - 2;
    localparam int unsigned WORDS    = 1 << S_WORD;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef logic [3:0][7:0]        word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_ALLOCATE
    } state_e;

    state_e state_q, state_d;

    logic          mem_resp_q, mem_resp_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          pmem_read_q, pmem_read_d;
    logic          pmem_write_q, pmem_write_d;
    logic [31:0]   pmem_address_q, pmem_address_d;
    line_t         pmem_wdata_q, pmem_wdata_d;

    line_t         data_q [NUM_SETS];
    logic [S_TAG-1:0] tag_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;

    logic [S_TAG-1:0]   addr_tag;
    logic [S_INDEX-1:0] addr_idx;
    logic [S_WORD-1:0]  addr_word;
    logic               unused_addr_lsb;

    line_t            cur_line;
    logic [S_TAG-1:0] cur_tag;
    line_t            fill_line;
    word_t            wdata_bytes;
    word_t            merged_word;
    line_t            merged_line;
    logic             hit_c;

    logic             line_we;
    line_t            line_wdata;
    logic             tag_we;

    assign addr_tag        = mem_address[31 -: S_TAG];
    assign addr_idx        = mem_address[S_OFFSET +: S_INDEX];
    assign addr_word       = mem_address[2 +: S_WORD];
    assign unused_addr_lsb = ^mem_address[1:0];

    assign cur_line    = data_q[addr_idx];
    assign cur_tag     = tag_q[addr_idx];
    assign fill_line   = pmem_rdata;
    assign wdata_bytes = mem_wdata;
    assign hit_c       = valid_q[addr_idx] && (cur_tag == addr_tag);

    // Byte-lane merge of the CPU store into the currently indexed line
    always_comb begin
        merged_word = cur_line[addr_word];
        for (int unsigned b = 0; b < 4; b++) begin
            if (mem_byte_enable[2'(b)]) begin
                merged_word[2'(b)] = wdata_bytes[2'(b)];
            end
        end
        merged_line            = cur_line;
        merged_line[addr_word] = merged_word;
    end

    // Next-state, array update and registered output logic
    always_comb begin
        state_d        = state_q;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        line_we        = 1'b0;
        line_wdata     = cur_line;
        tag_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = ST_COMPARE;
                    // Arrays are stable across IDLE, so the lookup result is known a cycle early
                    mem_resp_d  = hit_c;
                    mem_rdata_d = cur_line[addr_word];
                end
            end
            ST_COMPARE: begin
                if (hit_c) begin
                    state_d = ST_IDLE;
                    if (mem_write) begin
                        line_we           = 1'b1;
                        line_wdata        = merged_line;
                        dirty_d[addr_idx] = 1'b1;
                    end
                end else if (dirty_q[addr_idx]) begin
                    state_d        = ST_WRITEBACK;
                    pmem_write_d   = 1'b1;
                    pmem_address_d = {cur_tag, addr_idx, S_OFFSET'(0)};
                    pmem_wdata_d   = cur_line;
                end else begin
                    state_d        = ST_ALLOCATE;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {mem_address[31:S_OFFSET], S_OFFSET'(0)};
                end
            end
            ST_WRITEBACK: begin
                if (pmem_resp) begin
                    state_d           = ST_ALLOCATE;
                    pmem_write_d      = 1'b0;
                    pmem_read_d       = 1'b1;
                    pmem_address_d    = {mem_address[31:S_OFFSET], S_OFFSET'(0)};
                    dirty_d[addr_idx] = 1'b0;
                end
            end
            ST_ALLOCATE: begin
                if (pmem_resp) begin
                    state_d           = ST_COMPARE;
                    pmem_read_d       = 1'b0;
                    line_we           = 1'b1;
                    line_wdata        = fill_line;
                    tag_we            = 1'b1;
                    valid_d[addr_idx] = 1'b1;
                    dirty_d[addr_idx] = 1'b0;
                    // The refilled line always hits in the following COMPARE
                    mem_resp_d        = 1'b1;
                    mem_rdata_d       = fill_line[addr_word];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
        end
    end

    // Data and tag storage carry no reset; valid gates their use
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[addr_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[addr_idx] <= addr_tag;
        end
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios plus random traffic against a
// set-level cache model and a sparse line-addressed memory model.
module tb_l1_cache;

    typedef logic [7:0][31:0] line_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    l1_cache dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int checks   = 0;
    int failures = 0;
    bit started    = 1'b0;
    bit req_active = 1'b0;

    // Reference state: backing memory by line number, and per-set cache contents
    line_t       mem_m [int unsigned];
    line_t       c_data  [16];
    logic [22:0] c_tag   [16];
    bit          c_valid [16];
    bit          c_dirty [16];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t mem_line(input int unsigned ln);
        line_t l;
        if (mem_m.exists(ln)) return mem_m[ln];
        for (int w = 0; w < 8; w++) begin
            l[w] = ((ln << 3) | 32'(w)) ^ 32'h9E37_79B9;
        end
        return l;
    endfunction

    // Every-cycle protocol checks
    always @(negedge clk) begin
        if (started && rst_n === 1'b1) begin
            chk32("strobe_exclusive", 32'(pmem_read && pmem_write), 32'd0);
            if (pmem_read || pmem_write) begin
                chk32("pmem_align", 32'(pmem_address[4:0]), 32'd0);
            end
            if (!req_active) begin
                chk32("idle_strobes", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
            end
        end
    end

    // One CPU transaction; also plays the physical memory with the given wait counts
    task automatic txn(input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int wb_wait, input int fill_wait,
                       output logic [31:0] rdata_o, output logic [31:0] wb_word0_o,
                       output bit wb_seen, output bit fill_seen);
        int unsigned idx, w, exp_iter;
        logic [22:0] tg;
        bit          hit, dirty_miss, done;
        logic [31:0] victim_addr, exp_rdata, mask, word;
        line_t       victim_line;
        int          wb_cnt, fill_cnt;

        idx  = 32'(addr[8:5]);
        tg   = addr[31:9];
        w    = 32'(addr[4:2]);
        hit  = c_valid[idx] && (c_tag[idx] == tg);
        dirty_miss  = !hit && c_dirty[idx];
        victim_addr = {c_tag[idx], addr[8:5], 5'b0};
        victim_line = c_data[idx];
        exp_iter    = hit ? 1 : (dirty_miss ? 32'(wb_wait + fill_wait + 2) : 32'(fill_wait + 2));

        if (!hit) begin
            if (dirty_miss) mem_m[victim_addr >> 5] = victim_line;
            c_data[idx]  = mem_line(addr >> 5);
            c_tag[idx]   = tg;
            c_valid[idx] = 1'b1;
            c_dirty[idx] = 1'b0;
        end
        exp_rdata = c_data[idx][w];

        rdata_o = '0; wb_word0_o = '0; wb_seen = 1'b0; fill_seen = 1'b0;
        wb_cnt = 0; fill_cnt = 0; done = 1'b0;

        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_byte_enable = be; mem_wdata = wd;
        req_active = 1'b1;

        for (int iter = 1; iter <= 100 && !done; iter++) begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (pmem_write) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    wb_seen = 1'b1;
                    chk32("wb_expected", 32'(dirty_miss), 32'd1);
                    chk32("wb_start_cycle", 32'(iter), 32'd2);
                    chk32("wb_address", pmem_address, victim_addr);
                    chk256("wb_data", pmem_wdata, victim_line);
                    wb_word0_o = pmem_wdata[31:0];
                end
                if (wb_cnt == wb_wait) pmem_resp = 1'b1;
            end
            if (pmem_read) begin
                fill_cnt++;
                if (fill_cnt == 1) begin
                    fill_seen = 1'b1;
                    chk32("fill_expected", 32'(!hit), 32'd1);
                    chk32("fill_start_cycle", 32'(iter), dirty_miss ? 32'(wb_wait + 2) : 32'd2);
                    chk32("fill_address", pmem_address, {addr[31:5], 5'b0});
                end
                if (fill_cnt == fill_wait) begin
                    pmem_rdata = mem_line(addr >> 5);
                    pmem_resp  = 1'b1;
                end
            end
            if (mem_resp) begin
                done = 1'b1;
                chk32("resp_latency", 32'(iter), exp_iter);
                if (rd && !wr) chk32("read_data", mem_rdata, exp_rdata);
                rdata_o = mem_rdata;
            end
        end
        if (!done) chk32("resp_timeout", 32'd0, 32'd1);

        // Hold the request through the edge that commits a write hit
        @(posedge clk); #1;
        chk32("resp_single_pulse", 32'(mem_resp), 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        req_active = 1'b0;

        if (wr) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            word = c_data[idx][w];
            c_data[idx][w] = (word & ~mask) | (wd & mask);
            c_dirty[idx]   = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rdata, wb0;
        bit          wbs, fls;
        line_t       boot;
        int unsigned op;
        logic [31:0] a;

        rst_n = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c_valid[i] = 1'b0; c_dirty[i] = 1'b0; c_tag[i] = '0; c_data[i] = '0;
        end
        boot = mem_line(32'h4000_0000 >> 5);
        boot[0] = 32'h0000_0013;
        boot[1] = 32'h0050_0093;
        mem_m[32'h4000_0000 >> 5] = boot;

        repeat (3) @(posedge clk);
        #1;
        chk32("reset_outputs", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
        @(negedge clk); rst_n = 1'b1; started = 1'b1;
        @(posedge clk); #1;

        txn(32'h4000_0000, 1, 0, 4'h0, 32'h0, 1, 3, rdata, wb0, wbs, fls);
        chk32("t1_rdata", rdata, 32'h0000_0013);
        chk32("t1_fill", 32'(fls), 32'd1);

        txn(32'h4000_0004, 1, 0, 4'h0, 32'h0, 1, 1, rdata, wb0, wbs, fls);
        chk32("t2_rdata", rdata, 32'h0050_0093);
        chk32("t2_no_pmem", 32'({wbs, fls}), 32'd0);

        txn(32'h4000_0001, 0, 1, 4'b0010, 32'h0000_AB00, 1, 1, rdata, wb0, wbs, fls);
        chk32("t3_write_hit", 32'({wbs, fls}), 32'd0);
        txn(32'h4000_0000, 1, 0, 4'h0, 32'h0, 1, 1, rdata, wb0, wbs, fls);
        chk32("t3_rdata", rdata, 32'h0000_AB13);

        txn(32'h4000_0200, 1, 0, 4'h0, 32'h0, 3, 2, rdata, wb0, wbs, fls);
        chk32("t4_wb_seen", 32'(wbs), 32'd1);
        chk32("t4_wb_word0", wb0, 32'h0000_AB13);

        txn(32'h4000_0400, 1, 0, 4'h0, 32'h0, 1, 2, rdata, wb0, wbs, fls);
        chk32("t5_clean_victim", 32'({wbs, fls}), 32'd1);

        // Random traffic over four conflicting tags
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                pmem_resp = 1'b1;
                @(posedge clk); #1;
                pmem_resp = 1'b0;
            end
            a  = 32'h4000_0000 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 15) << 5)
               + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            op = $urandom_range(0, 2);
            txn(a, op != 1, op != 0, 4'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), rdata, wb0, wbs, fls);
        end

        // Reset while a fill is outstanding
        mem_address = 32'h4000_0E00; mem_read = 1'b1; mem_write = 1'b0;
        req_active = 1'b1;
        fls = 1'b0;
        for (int i = 0; i < 50 && !fls; i++) begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (pmem_write) begin
                mem_m[pmem_address >> 5] = pmem_wdata;
                pmem_resp = 1'b1;
            end
            if (pmem_read) fls = 1'b1;
        end
        chk32("t6_fill_reached", 32'(fls), 32'd1);
        req_active = 1'b0;
        rst_n = 1'b0;
        #1;
        chk32("t6_async_drop", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
        mem_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c_valid[i] = 1'b0; c_dirty[i] = 1'b0;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        txn(32'h4000_0000, 1, 0, 4'h0, 32'h0, 1, 2, rdata, wb0, wbs, fls);
        chk32("t6_miss_after_reset", 32'({wbs, fls}), 32'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
